// File: rtl/pix_readout_packer_pkg.sv
// Shared definitions for the 12-bit pixel readout packer: FSM encoding,
// packed-group lengths, count-width helper and the byte-lane selector.
package pix_readout_packer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH0  = 3'd1,
        ST_FETCH1  = 3'd2,
        ST_EMIT    = 3'd3,
        ST_TRAILER = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // A full pixel pair packs into three bytes; a lone final pixel into two.
    localparam logic [1:0] GROUP_LEN_FULL = 2'd3;
    localparam logic [1:0] GROUP_LEN_LONE = 2'd2;

    localparam int IMAGE_WIDTH_MAX_DEFAULT  = 256;
    localparam int IMAGE_HEIGHT_MAX_DEFAULT = 256;

    function automatic int reg_width(input int value);
        return $clog2(value + 1);
    endfunction

    localparam int COUNT_WIDTH_DEFAULT =
        reg_width(IMAGE_WIDTH_MAX_DEFAULT * IMAGE_HEIGHT_MAX_DEFAULT);

    function automatic logic [7:0] pack_byte(input logic [11:0] p0,
                                             input logic [11:0] p1,
                                             input logic [1:0]  idx,
                                             input logic        lone);
        logic [7:0] b;
        case (idx)
            2'd0:    b = p0[7:0];
            2'd1:    b = lone ? {4'h0, p0[11:8]} : {p1[3:0], p0[11:8]};
            2'd2:    b = p1[11:4];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pix_readout_packer_if.sv
// Command, upstream readout, downstream byte stream and status signals of the packer.
interface pix_readout_packer_if
    import pix_readout_packer_pkg::*;
#(
    parameter int CountWidth = COUNT_WIDTH_DEFAULT
) ();

    logic                  cmd_start;
    logic [CountWidth-1:0] cmd_pixelCount;
    logic                  cmd_abort;
    logic                  readout_ready;
    logic                  readout_trigger;
    logic [15:0]           readout_data;
    logic                  out_ready;
    logic                  out_trigger;
    logic [7:0]            out_data;
    logic                  status_busy;
    logic                  status_done;

    modport slave (
        input  cmd_start, cmd_pixelCount, cmd_abort,
        input  readout_ready, readout_data, out_trigger,
        output readout_trigger, out_ready, out_data, status_busy, status_done
    );

    modport master (
        output cmd_start, cmd_pixelCount, cmd_abort,
        output readout_ready, readout_data, out_trigger,
        input  readout_trigger, out_ready, out_data, status_busy, status_done
    );

endinterface

// File: rtl/pix_readout_packer_checksum.sv
// 16-bit wrapping byte accumulator for the trailer; only instantiated when
// PIX_READOUT_PACKER_CHECKSUM_EN is defined.
module pix_readout_packer_checksum (
    input  logic        clk,
    input  logic        rst_,
    input  logic        clear_i,
    input  logic        add_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] sum_o
);

    logic [15:0] sum_q;
    logic [15:0] sum_d;

    // Clear wins over add so a new frame always starts from zero.
    always_comb begin
        if (clear_i) begin
            sum_d = 16'h0000;
        end else if (add_i) begin
            sum_d = sum_q + {8'h00, byte_i};
        end else begin
            sum_d = sum_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sum_q <= 16'h0000;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/pix_readout_packer.sv
// Packs 12-bit pixel pairs from the readout port into 3-byte groups on a byte stream.
// Optional checksum trailer enabled by PIX_READOUT_PACKER_CHECKSUM_EN.
module pix_readout_packer
    import pix_readout_packer_pkg::*;
#(
    parameter int ImageWidthMax  = 256,
    parameter int ImageHeightMax = 256
) (
    input  logic                clk,
    input  logic                rst_,
    pix_readout_packer_if.slave bus
);

    localparam int CountWidth = reg_width(ImageWidthMax * ImageHeightMax);
    localparam logic [CountWidth-1:0] CntZero = {CountWidth{1'b0}};
    localparam logic [CountWidth-1:0] CntOne  = {{(CountWidth-1){1'b0}}, 1'b1};

`ifdef PIX_READOUT_PACKER_CHECKSUM_EN
    localparam state_e AfterPixels = ST_TRAILER;
`else
    localparam state_e AfterPixels = ST_DONE;
`endif

    state_e                state_q, state_d;
    logic [CountWidth-1:0] remaining_q, remaining_d;
    logic [11:0]           p0_q, p0_d;
    logic [11:0]           p1_q, p1_d;
    logic [1:0]            last_len_q, last_len_d;
    logic [1:0]            idx_q, idx_d;
    logic                  out_ready_q, out_ready_d;
    logic [7:0]            out_data_q, out_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  start_s;
    logic                  rd_xfer_s;
    logic                  out_xfer_s;
    logic                  last_byte_s;
    logic                  emitting_s;
    logic [1:0]            sel_idx_s;
    logic [7:0]            emit_byte_s;
    logic                  unused_data_hi_s;

    assign start_s          = (state_q == ST_IDLE) && bus.cmd_start && !bus.cmd_abort;
    assign bus.readout_trigger = (state_q == ST_FETCH0) || (state_q == ST_FETCH1);
    assign rd_xfer_s        = bus.readout_ready && bus.readout_trigger;
    assign out_xfer_s       = out_ready_q && bus.out_trigger;
    assign last_byte_s      = (idx_q == (last_len_q - 2'd1));
    assign unused_data_hi_s = ^bus.readout_data[15:12];

    // While a byte is presented, the next one to load is idx+1.
    assign sel_idx_s = out_ready_q ? (idx_q + 2'd1) : idx_q;

`ifdef PIX_READOUT_PACKER_CHECKSUM_EN
    logic [15:0] sum_s;

    pix_readout_packer_checksum u_checksum (
        .clk     (clk),
        .rst_    (rst_),
        .clear_i (start_s),
        .add_i   (out_xfer_s && (state_q == ST_EMIT)),
        .byte_i  (out_data_q),
        .sum_o   (sum_s)
    );

    assign emitting_s  = (state_q == ST_EMIT) || (state_q == ST_TRAILER);
    assign emit_byte_s = (state_q == ST_TRAILER)
                       ? (sel_idx_s[0] ? sum_s[15:8] : sum_s[7:0])
                       : pack_byte(p0_q, p1_q, sel_idx_s, last_len_q == GROUP_LEN_LONE);
`else
    assign emitting_s  = (state_q == ST_EMIT);
    assign emit_byte_s = pack_byte(p0_q, p1_q, sel_idx_s, last_len_q == GROUP_LEN_LONE);
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        if (bus.cmd_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_d = (bus.cmd_pixelCount == CntZero) ? AfterPixels : ST_FETCH0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH0: begin
                    if (rd_xfer_s) begin
                        state_d = (remaining_q == CntOne) ? ST_EMIT : ST_FETCH1;
                    end else begin
                        state_d = ST_FETCH0;
                    end
                end
                ST_FETCH1: begin
                    if (rd_xfer_s) begin
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_FETCH1;
                    end
                end
                ST_EMIT: begin
                    if (out_xfer_s && last_byte_s) begin
                        state_d = (remaining_q != CntZero) ? ST_FETCH0 : AfterPixels;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end
`ifdef PIX_READOUT_PACKER_CHECKSUM_EN
                ST_TRAILER: begin
                    if (out_xfer_s && last_byte_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_TRAILER;
                    end
                end
`endif
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next values: pixel capture, byte sequencing, status.
    always_comb begin
        remaining_d = remaining_q;
        p0_d        = p0_q;
        p1_d        = p1_q;
        last_len_d  = last_len_q;
        idx_d       = idx_q;
        out_ready_d = out_ready_q;
        out_data_d  = out_data_q;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_q == ST_DONE) && !bus.cmd_abort;
        if (bus.cmd_abort) begin
            out_ready_d = 1'b0;
            idx_d       = 2'd0;
        end else if (emitting_s) begin
            if (!out_ready_q) begin
                out_ready_d = 1'b1;
                out_data_d  = emit_byte_s;
            end else if (out_xfer_s) begin
                if (last_byte_s) begin
                    out_ready_d = 1'b0;
                    idx_d       = 2'd0;
                    // A following trailer is two bytes long.
                    last_len_d  = GROUP_LEN_LONE;
                end else begin
                    idx_d      = idx_q + 2'd1;
                    out_data_d = emit_byte_s;
                end
            end else begin
                out_ready_d = out_ready_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        remaining_d = bus.cmd_pixelCount;
                        last_len_d  = GROUP_LEN_LONE;
                        idx_d       = 2'd0;
                    end else begin
                        remaining_d = remaining_q;
                    end
                end
                ST_FETCH0: begin
                    if (rd_xfer_s) begin
                        p0_d        = bus.readout_data[11:0];
                        remaining_d = remaining_q - CntOne;
                        last_len_d  = GROUP_LEN_LONE;
                        idx_d       = 2'd0;
                    end else begin
                        p0_d = p0_q;
                    end
                end
                ST_FETCH1: begin
                    if (rd_xfer_s) begin
                        p1_d        = bus.readout_data[11:0];
                        remaining_d = remaining_q - CntOne;
                        last_len_d  = GROUP_LEN_FULL;
                        idx_d       = 2'd0;
                    end else begin
                        p1_d = p1_q;
                    end
                end
                default: begin
                    idx_d = idx_q;
                end
            endcase
        end
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            remaining_q <= CntZero;
            p0_q        <= 12'h000;
            p1_q        <= 12'h000;
            last_len_q  <= 2'd0;
            idx_q       <= 2'd0;
            out_ready_q <= 1'b0;
            out_data_q  <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            last_len_q  <= last_len_d;
            idx_q       <= idx_d;
            out_ready_q <= out_ready_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_ready   = out_ready_q;
    assign bus.out_data    = out_data_q;
    assign bus.status_busy = busy_q;
    assign bus.status_done = done_q;

endmodule

// File: tb/tb_pix_readout_packer.sv
// Self-checking bench for pix_readout_packer: fixed vectors, corner sequences and
// random frames against a bit-stream reference model.
module tb_pix_readout_packer;
    import pix_readout_packer_pkg::*;

    localparam int CW = COUNT_WIDTH_DEFAULT;

    logic clk  = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    pix_readout_packer_if bus ();

    pix_readout_packer dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    typedef struct {
        int               n;
        logic [3:0][11:0] px;
        int               len;
        logic [5:0][7:0]  exp;
        int               stall;
        int               bp;
    } vec_t;

    vec_t        vecs [5];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] up_q [$];
    logic [11:0] frame_pix [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          stall_pct = 0;
    int          bp_pct = 0;
    int          hold_at = -1;
    int          hold_left = 0;
    int          held_cycles = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          viol = 0;
    int          cyc = 0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive at +1, sample on negedge, book transfers after posedge.
    task automatic step();
        logic       rdx;
        logic       outx;
        logic [7:0] b;
        if (up_q.size() > 0 && $urandom_range(99) >= stall_pct) begin
            bus.readout_ready = 1'b1;
            bus.readout_data  = up_q[0];
        end else begin
            bus.readout_ready = 1'b0;
            bus.readout_data  = 16'($urandom);
        end
        if (hold_at >= 0 && got_q.size() == hold_at && bus.out_ready) begin
            hold_left = 10;
            hold_at   = -1;
        end
        bus.out_trigger = (hold_left > 0) ? 1'b0 : ($urandom_range(99) >= bp_pct);
        @(negedge clk);
        rdx  = bus.readout_ready && bus.readout_trigger;
        outx = bus.out_ready && bus.out_trigger;
        b    = bus.out_data;
        if (prev_hold && !(bus.out_ready && bus.out_data == prev_data)) viol++;
        if (bus.out_ready && bus.readout_trigger) viol++;
        prev_hold = bus.out_ready && !bus.out_trigger && !bus.cmd_abort;
        prev_data = bus.out_data;
        if (hold_left > 0 && bus.out_ready) held_cycles++;
        if (bus.status_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (rdx) void'(up_q.pop_front());
        if (outx) got_q.push_back(b);
        bus.cmd_start = 1'b0;
        bus.cmd_abort = 1'b0;
        if (hold_left > 0) hold_left--;
        cyc++;
    endtask

    task automatic add_trailer();
`ifdef PIX_READOUT_PACKER_CHECKSUM_EN
        int s = 0;
        foreach (exp_q[i]) s = (s + int'(exp_q[i])) % 65536;
        exp_q.push_back(8'(s));
        exp_q.push_back(8'(s >> 8));
`endif
    endtask

    // Reference: pixels form an LSB-first 12-bit stream cut into bytes, last byte zero-padded.
    task automatic model_bytes();
        int acc;
        int nbits;
        exp_q.delete();
        acc   = 0;
        nbits = 0;
        foreach (frame_pix[i]) begin
            acc   = acc | (int'(frame_pix[i]) << nbits);
            nbits = nbits + 12;
            while (nbits >= 8) begin
                exp_q.push_back(8'(acc));
                acc   = acc >> 8;
                nbits = nbits - 8;
            end
        end
        if (nbits > 0) exp_q.push_back(8'(acc));
        add_trailer();
    endtask

    task automatic run_frame(input string name, input int n, input int stall, input int bp);
        int k;
        got_q.delete();
        up_q.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        viol        = 0;
        held_cycles = 0;
        foreach (frame_pix[i]) up_q.push_back({4'($urandom_range(15)), frame_pix[i]});
        up_q.push_back(16'hFEED);
        stall_pct = stall;
        bp_pct    = bp;
        bus.cmd_pixelCount = CW'(n);
        bus.cmd_start      = 1'b1;
        k = cyc;
        step();
        check({name, " busy_after_start"}, 32'(bus.status_busy), 32'd1);
        while (done_cnt == 0 && cyc - k < 4000) step();
        check({name, " done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) step();
        check({name, " done_pulses"}, 32'(done_cnt), 32'd1);
        check({name, " busy_end"}, 32'(bus.status_busy), 32'd0);
        check({name, " ready_end"}, 32'(bus.out_ready), 32'd0);
        check({name, " byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        check({name, " words_consumed"}, 32'(up_q.size()), 32'd1);
        check({name, " protocol"}, 32'(viol), 32'd0);
`ifndef PIX_READOUT_PACKER_CHECKSUM_EN
        if (n == 0) check({name, " done_latency"}, 32'(done_cyc - k), 32'd2);
`endif
    endtask

    initial begin
        int n;
        int k;

        vecs[0] = '{n: 2, px: {12'h000, 12'h000, 12'h123, 12'hABC}, len: 3,
                    exp: {8'h00, 8'h00, 8'h00, 8'h12, 8'h3A, 8'hBC}, stall: 0, bp: 0};
        vecs[1] = '{n: 3, px: {12'h000, 12'hFFF, 12'h123, 12'hABC}, len: 5,
                    exp: {8'h00, 8'h0F, 8'hFF, 8'h12, 8'h3A, 8'hBC}, stall: 0, bp: 0};
        vecs[2] = '{n: 1, px: {12'h000, 12'h000, 12'h000, 12'h5A5}, len: 2,
                    exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'hA5}, stall: 20, bp: 20};
        vecs[3] = '{n: 0, px: {12'h000, 12'h000, 12'h000, 12'h000}, len: 0,
                    exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, stall: 0, bp: 0};
        vecs[4] = '{n: 4, px: {12'h7FE, 12'h801, 12'hFFF, 12'h000}, len: 6,
                    exp: {8'h7F, 8'hE8, 8'h01, 8'hFF, 8'hF0, 8'h00}, stall: 30, bp: 30};

        bus.cmd_start      = 1'b0;
        bus.cmd_abort      = 1'b0;
        bus.cmd_pixelCount = '0;
        bus.readout_ready  = 1'b0;
        bus.readout_data   = 16'h0000;
        bus.out_trigger    = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset out_ready", 32'(bus.out_ready), 32'd0);
        check("reset out_data", 32'(bus.out_data), 32'd0);
        check("reset busy", 32'(bus.status_busy), 32'd0);
        check("reset done", 32'(bus.status_done), 32'd0);
        check("reset readout_trigger", 32'(bus.readout_trigger), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;

        // Fixed vectors
        for (int v = 0; v < 5; v++) begin
            frame_pix.delete();
            exp_q.delete();
            for (int i = 0; i < vecs[v].n; i++) frame_pix.push_back(vecs[v].px[i]);
            for (int i = 0; i < vecs[v].len; i++) exp_q.push_back(vecs[v].exp[i]);
            add_trailer();
            run_frame($sformatf("vec%0d", v), vecs[v].n, vecs[v].stall, vecs[v].bp);
        end

        // Backpressure: 10 cycles of out_trigger low after byte0
        frame_pix = '{12'hABC, 12'h123};
        model_bytes();
        hold_at = 1;
        run_frame("backpressure", 2, 0, 0);
        check("backpressure held_cycles", 32'(held_cycles), 32'd10);

        // Abort while byte1 is presented
        got_q.delete();
        up_q.delete();
        up_q.push_back(16'h3ABC);
        up_q.push_back(16'hC123);
        done_cnt  = 0;
        stall_pct = 0;
        bp_pct    = 0;
        bus.cmd_pixelCount = CW'(2);
        bus.cmd_start      = 1'b1;
        k = cyc;
        while (got_q.size() < 1 && cyc - k < 50) step();
        check("abort setup bytes", 32'(got_q.size()), 32'd1);
        check("abort setup ready", 32'(bus.out_ready), 32'd1);
        bp_pct = 100;
        bus.cmd_abort = 1'b1;
        step();
        check("abort out_ready", 32'(bus.out_ready), 32'd0);
        check("abort busy", 32'(bus.status_busy), 32'd0);
        bp_pct = 0;
        repeat (4) step();
        check("abort no_done", 32'(done_cnt), 32'd0);
        check("abort no_more_bytes", 32'(got_q.size()), 32'd1);

        // Reset while waiting in Fetch1
        up_q.delete();
        up_q.push_back(16'h7555);
        bus.cmd_pixelCount = CW'(2);
        bus.cmd_start      = 1'b1;
        k = cyc;
        while (up_q.size() != 0 && cyc - k < 50) step();
        check("fetch1 readout_trigger", 32'(bus.readout_trigger), 32'd1);
        rst_ = 1'b0;
        #1;
        check("midreset out_ready", 32'(bus.out_ready), 32'd0);
        check("midreset busy", 32'(bus.status_busy), 32'd0);
        check("midreset readout_trigger", 32'(bus.readout_trigger), 32'd0);
        prev_hold = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        frame_pix = '{12'hABC, 12'h123};
        exp_q = '{8'hBC, 8'h3A, 8'h12};
        add_trailer();
        run_frame("post_reset", 2, 0, 0);

        // Random frames against the reference model
        for (int f = 0; f < 24; f++) begin
            n = (f == 23) ? 41 : $urandom_range(0, 9);
            frame_pix.delete();
            for (int i = 0; i < n; i++) frame_pix.push_back(12'($urandom_range(0, 4095)));
            model_bytes();
            run_frame($sformatf("rand%0d", f), n, $urandom_range(0, 60), $urandom_range(0, 60));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
